// File: rtl/state_number_seq.sv
`default_nettype none
// ============================================================================
// Module      : state_number_seq
// Description : Control-FSM state register with a runtime-programmable
//               per-state number table. Supports up/down stepping with wrap
//               detection, direct state load and table writes (with
//               same-edge write bypass). All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module state_number_seq #(
    parameter int STATE_W     = 3,
    parameter int NUM_W       = 4,
    parameter int NUM_STATES  = 6,
    parameter int RESET_STATE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               dir,
    input  logic               load,
    input  logic [STATE_W-1:0] load_state,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_addr,
    input  logic [NUM_W-1:0]   cfg_data,
    output logic [STATE_W-1:0] state,
    output logic [NUM_W-1:0]   number,
    output logic               wrap,
    output logic               err
);

    localparam logic [STATE_W-1:0] c_last_state  = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W-1:0] c_reset_state = STATE_W'(RESET_STATE);
    localparam logic [NUM_W-1:0]   c_reset_num   = NUM_W'(RESET_STATE);

    logic [STATE_W-1:0] r_state;
    logic [NUM_W-1:0]   r_number;
    logic               r_wrap;
    logic               r_err;
    logic [NUM_W-1:0]   r_table [NUM_STATES];

    logic               w_load_in_range;
    logic               w_cfg_in_range;
    logic               w_bad_load;
    logic               w_bad_cfg;
    logic               w_wrap;
    logic [STATE_W-1:0] w_next;
    logic [NUM_W-1:0]   w_next_num;

    // Range qualification is done at 32 bits so NUM_STATES == 2**STATE_W works.
    assign w_load_in_range = (32'(load_state) < NUM_STATES);
    assign w_cfg_in_range  = (32'(cfg_addr) < NUM_STATES);
    assign w_bad_cfg       = cfg_we && !w_cfg_in_range;

    // Next-state selection: load beats step; an illegal load freezes the state.
    always_comb begin
        w_next     = r_state;
        w_wrap     = 1'b0;
        w_bad_load = 1'b0;
        if (load) begin
            if (w_load_in_range) begin
                w_next = load_state;
            end else begin
                w_bad_load = 1'b1;
            end
        end else if (step) begin
            if (dir) begin
                if (r_state == c_last_state) begin
                    w_next = '0;
                    w_wrap = 1'b1;
                end else begin
                    w_next = r_state + STATE_W'(1);
                end
            end else begin
                if (r_state == '0) begin
                    w_next = c_last_state;
                    w_wrap = 1'b1;
                end else begin
                    w_next = r_state - STATE_W'(1);
                end
            end
        end
    end

    // Number for the entered state, forwarding a same-edge write to that entry.
    always_comb begin
        w_next_num = r_table[w_next];
        if (cfg_we && w_cfg_in_range && (cfg_addr == w_next)) begin
            w_next_num = cfg_data;
        end
    end

    // Number table: identity contents on reset, otherwise in-range writes only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                r_table[i] <= NUM_W'(i);
            end
        end else if (cfg_we && w_cfg_in_range) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    // State, number and the single-cycle wrap/err pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_reset_state;
            r_number <= c_reset_num;
            r_wrap   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_number <= w_next_num;
            r_wrap   <= w_wrap;
            r_err    <= w_bad_load || w_bad_cfg;
        end
    end

    assign state  = r_state;
    assign number = r_number;
    assign wrap   = r_wrap;
    assign err    = r_err;

endmodule
`default_nettype wire
